// File: rtl/digital_clock_pkg.sv
// digital_clock_pkg: shared mode type, segment table and display digit indices.
package digital_clock_pkg;

    typedef enum logic [1:0] {NORMAL, ADJ_HOUR, ADJ_MIN} mode_t;

    // Active-low {g,f,e,d,c,b,a}, indexed by BCD value.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [2:0] DIG_S1  = 3'd0;
    localparam logic [2:0] DIG_S10 = 3'd1;
    localparam logic [2:0] DIG_M1  = 3'd2;
    localparam logic [2:0] DIG_M10 = 3'd3;
    localparam logic [2:0] DIG_H1  = 3'd4;
    localparam logic [2:0] DIG_H10 = 3'd5;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d > 4'd9) ? 7'b1111111 : SEG_TABLE[d];
    endfunction

endpackage

// File: rtl/digital_clock_key_debounce.sv
// key_debounce: synchronizes an active-low key, debounces it and emits a one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, armed_q, armed_d, press_q, press_d;

    // Synchronizer resets to "held" so a key pressed across reset is never armed until seen released.
    always_comb begin
        sync_d  = {sync_q[0], key_n};
        armed_d = armed_q | (sync_q[1] & level_q);
        cnt_d   = (sync_q[1] != level_q) ? cnt_q + CW'(1) : '0;
        level_d = level_q;
        if (sync_q[1] != level_q && cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end
        press_d = armed_q & level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/digital_clock.sv
// digital_clock: HH:MM:SS clock with mode/increment keys for time setting and a
// scanned six-digit active-low 7-segment display.
module digital_clock
    import digital_clock_pkg::*;
#(
    parameter int CLK_PER_SEC  = 50,
    parameter int SCAN_DIV     = 2,
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [6:0] seg_out,
    output logic [5:0] digit_sel
);
    localparam int PW = $clog2(CLK_PER_SEC + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);

    mode_t         mode_q, mode_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    h10_q, h10_d, h1_q, h1_d, m10_q, m10_d, m1_q, m1_d, s10_q, s10_d, s1_q, s1_d;
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    sel_q, sel_d;
    logic          mode_p, inc_p, tick, s_carry, m_carry, inc_min, inc_hr, h_wrap;
    logic [3:0]    cur;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (.clk(clk), .rst(rst), .key_n(key_mode), .press(mode_p));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc  (.clk(clk), .rst(rst), .key_n(key_inc),  .press(inc_p));

    always_comb begin
        {h10_d, h1_d, m10_d, m1_d, s10_d, s1_d} = {h10_q, h1_q, m10_q, m1_q, s10_q, s1_q};
        tick    = (mode_q == NORMAL) && (pre_q == PW'(CLK_PER_SEC - 1));
        pre_d   = (mode_q != NORMAL || mode_p || tick) ? '0 : pre_q + PW'(1);
        s_carry = tick && s1_q == 4'd9 && s10_q == 4'd5;
        m_carry = s_carry && m1_q == 4'd9 && m10_q == 4'd5;
        // A mode press in the same cycle swallows the inc press.
        inc_min = s_carry || (mode_q == ADJ_MIN && inc_p && !mode_p);
        inc_hr  = m_carry || (mode_q == ADJ_HOUR && inc_p && !mode_p);
        h_wrap  = h10_q == 4'd2 && h1_q == 4'd3;
        if (tick) begin
            s1_d = (s1_q == 4'd9) ? 4'd0 : s1_q + 4'd1;
            if (s1_q == 4'd9)
                s10_d = (s10_q == 4'd5) ? 4'd0 : s10_q + 4'd1;
        end
        if (inc_min) begin
            m1_d = (m1_q == 4'd9) ? 4'd0 : m1_q + 4'd1;
            if (m1_q == 4'd9)
                m10_d = (m10_q == 4'd5) ? 4'd0 : m10_q + 4'd1;
        end
        if (inc_hr) begin
            h1_d  = (h_wrap || h1_q == 4'd9) ? 4'd0 : h1_q + 4'd1;
            h10_d = h_wrap ? 4'd0 : (h1_q == 4'd9) ? h10_q + 4'd1 : h10_q;
        end
        mode_d = !mode_p ? mode_q : (mode_q == NORMAL) ? ADJ_HOUR : (mode_q == ADJ_HOUR) ? ADJ_MIN : NORMAL;
        if (mode_p && mode_q == NORMAL) begin
            s1_d  = 4'd0;
            s10_d = 4'd0;
        end
        div_d = (div_q == SW'(SCAN_DIV - 1)) ? '0 : div_q + SW'(1);
        idx_d = (div_q != SW'(SCAN_DIV - 1)) ? idx_q : (idx_q == DIG_H10) ? DIG_S1 : idx_q + 3'd1;
        sel_d = ~(6'b000001 << idx_d);
        cur   = (idx_d == DIG_S1)  ? s1_d  :
                (idx_d == DIG_S10) ? s10_d :
                (idx_d == DIG_M1)  ? m1_d  :
                (idx_d == DIG_M10) ? m10_d :
                (idx_d == DIG_H1)  ? h1_d  : h10_d;
        seg_d = seg_of(cur);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= NORMAL;
            pre_q  <= '0;
            div_q  <= '0;
            idx_q  <= DIG_S1;
            {h10_q, h1_q, m10_q, m1_q, s10_q, s1_q} <= '0;
            seg_q  <= 7'b1000000;
            sel_q  <= 6'b111110;
        end else begin
            mode_q <= mode_d;
            pre_q  <= pre_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            {h10_q, h1_q, m10_q, m1_q, s10_q, s1_q} <= {h10_d, h1_d, m10_d, m1_d, s10_d, s1_d};
            seg_q  <= seg_d;
            sel_q  <= sel_d;
        end
    end

    assign seg_out   = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_digital_clock.sv
// tb_digital_clock: directed key sequences; a monitor rebuilds the scanned display and checks it against queued times.
module tb_digital_clock;
    localparam int CPS = 50;
    localparam int SD  = 2;
    localparam int DB  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_mode = 1'b1;
    logic       key_inc = 1'b1;
    logic [6:0] seg_out;
    logic [5:0] digit_sel;
    int         total = 0;
    int         bad = 0;
    logic [23:0] exp_q[$];
    string       name_q[$];

    digital_clock #(.CLK_PER_SEC(CPS), .SCAN_DIV(SD), .DEBOUNCE_CYC(DB)) dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
        .seg_out(seg_out), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dec(input logic [6:0] s);
        case (s)
            7'b1000000: return 4'd0;
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            default:    return 4'hf;
        endcase
    endfunction

    function automatic logic [23:0] t(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Monitor: whenever a time is queued, collect one digit per digit_sel code and compare the full display.
    initial begin
        logic [23:0] disp;
        logic [5:0]  seen;
        int          idx;
        disp = '0;
        seen = '0;
        idx  = 0;
        forever begin
            @(negedge clk);
            if (!rst || exp_q.size() == 0) begin
                seen = '0;
            end else begin
                total++;
                if ($countones(~digit_sel) != 1) begin
                    bad++;
                    $display("FAIL onehot: digit_sel=%b, required exactly one low bit", digit_sel);
                end else begin
                    for (int k = 0; k < 6; k++) if (!digit_sel[k]) idx = k;
                    disp[idx*4 +: 4] = dec(seg_out);
                    seen[idx] = 1'b1;
                    if (&seen) begin
                        total++;
                        if (disp !== exp_q[0]) begin
                            bad++;
                            $display("FAIL %s: shown %h required %h", name_q[0], disp, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                        void'(name_q.pop_front());
                        seen = '0;
                    end
                end
            end
        end
    end

    task automatic check_time(input string nm, input logic [23:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: no full display scan within 100 cycles, required %h", nm, e);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic press(input bit m, input bit i, input int low);
        @(negedge clk);
        if (m) key_mode = 1'b0;
        if (i) key_inc = 1'b0;
        repeat (low) @(negedge clk);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic presses(input bit m, input bit i, input int n);
        for (int k = 0; k < n; k++) press(m, i, 6);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total += 2;
        if (digit_sel !== 6'b111110) begin
            bad++;
            $display("FAIL %s_sel: digit_sel=%b required 111110", nm, digit_sel);
        end
        if (seg_out !== 7'b1000000) begin
            bad++;
            $display("FAIL %s_seg: seg_out=%b required 1000000", nm, seg_out);
        end
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] mask;
        do_reset("reset");
        mask = '0;
        repeat (12) begin
            @(negedge clk);
            mask |= ~digit_sel;
        end
        total++;
        if (mask !== 6'h3f) begin
            bad++;
            $display("FAIL scan_cover: visited %b required 111111", mask);
        end
        repeat (2 * CPS + 2 - 12) @(negedge clk);
        check_time("free_run_2s", t(0, 0, 2));

        press(1, 0, 6);
        presses(0, 1, 2);
        press(1, 0, 6);
        presses(0, 1, 3);
        press(1, 0, 6);
        check_time("set_02_03", t(2, 3, 0));
        repeat (3 * CPS) @(negedge clk);
        check_time("run_3s", t(2, 3, 3));

        do_reset("reset_pre");
        press(1, 0, 6);
        presses(0, 1, 23);
        press(1, 0, 6);
        presses(0, 1, 59);
        check_time("preload", t(23, 59, 0));
        press(1, 0, 6);
        repeat (59 * CPS) @(negedge clk);
        check_time("pre_roll", t(23, 59, 59));
        repeat (40) @(negedge clk);
        check_time("rollover", t(0, 0, 0));

        press(1, 0, 6);
        presses(0, 1, 23);
        check_time("hour_23", t(23, 0, 0));
        press(0, 1, 6);
        check_time("hour_wrap", t(0, 0, 0));

        press(1, 1, 6);
        check_time("same_cycle", t(0, 0, 0));
        press(0, 1, 6);
        check_time("now_adj_min", t(0, 1, 0));
        press(0, 1, DB - 1);
        check_time("glitch", t(0, 1, 0));
        press(0, 1, 5);
        check_time("min_plus1", t(0, 2, 0));

        press(1, 0, 6);
        press(0, 1, 6);
        check_time("inc_normal", t(0, 2, 0));

        press(1, 0, 6);
        presses(0, 1, 5);
        press(1, 0, 6);
        presses(0, 1, 5);
        check_time("at_05_07", t(5, 7, 0));
        @(negedge clk);
        key_mode = 1'b0;
        do_reset("reset_mid");
        repeat (20) @(negedge clk);
        key_mode = 1'b1;
        repeat (40) @(negedge clk);
        check_time("after_reset", t(0, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digital_clock.md
DIGITAL_CLOCK -- requirements
Module: digital_clock

Interface
REQ-001 Parameter CLK_PER_SEC, 50, clock cycles per counted second; simulation default, synthesis overrides to 50_000_000.
REQ-002 Parameter SCAN_DIV, 2, clock cycles each display digit stays selected; synthesis uses 50_000.
REQ-003 Parameter DEBOUNCE_CYC, 3, consecutive stable synchronized samples needed to accept a key level change.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 key_mode  input  1  mode key, active-low (1 = released), asynchronous to clk.
REQ-007 key_inc  input  1  increment key, active-low (1 = released), asynchronous to clk.
REQ-008 seg_out  output  7  segment drive, active-low; bit order {g,f,e,d,c,b,a}, seg_out[0] = a.
REQ-009 digit_sel  output  6  digit enable, active-low one-hot; [5] = hour tens, [4] = hour ones, [3] = minute tens, [2] = minute ones, [1] = second tens, [0] = second ones.

Function
REQ-010 Each key SHALL pass through a 2-flop synchronizer and then a debouncer. The debouncer accepts a new level after DEBOUNCE_CYC equal samples.
REQ-011 A debounced 1->0 transition SHALL produce a one-cycle press pulse; releasing a key produces no pulse.
REQ-012 Mode FSM states SHALL be NORMAL, ADJ_HOUR, ADJ_MIN. A mode pulse advances NORMAL->ADJ_HOUR->ADJ_MIN->NORMAL.
REQ-013 A prescaler SHALL count 0..CLK_PER_SEC-1 and emit a one-cycle tick on wrap; it counts only in NORMAL.
REQ-014 In NORMAL, each tick SHALL advance the time. Seconds 59->00 carry into minutes; minutes 59->00 carry into hours; 23:59:59 wraps to 00:00:00.
REQ-015 On entering ADJ_HOUR, seconds SHALL clear to 00 and the prescaler SHALL clear to 0. Time does not advance in ADJ_HOUR or ADJ_MIN.
REQ-016 In ADJ_HOUR, an inc pulse SHALL add 1 to hours, wrapping 23->00; minutes are unaffected.
REQ-017 In ADJ_MIN, an inc pulse SHALL add 1 to minutes, wrapping 59->00, with no carry into hours.
REQ-018 In NORMAL, an inc pulse SHALL be ignored.
REQ-019 If mode and inc pulses occur in the same cycle, the mode pulse SHALL act and the inc pulse SHALL be discarded.
REQ-020 On leaving ADJ_MIN for NORMAL, the prescaler SHALL restart from 0. The first tick occurs CLK_PER_SEC cycles later.
REQ-021 Time SHALL be held as six BCD digits (hour tens 0-2, hour ones, minute tens 0-5, minute ones, second tens 0-5, second ones); hours never exceed 23.
REQ-022 Display scan SHALL select digits in the order [0],[1],[2],[3],[4],[5], then repeat, advancing every SCAN_DIV cycles. Exactly one digit_sel bit is 0 at all times.
REQ-023 seg_out SHALL be the active-low 7-segment code of the selected digit's BCD value (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
REQ-024 seg_out and digit_sel SHALL be registered and change on the same clock edge.
REQ-025 All display digits SHALL be shown steadily, with no blanking or blinking, in every mode.

Reset
REQ-026 While rst=0 at a clk edge, the following SHALL be set:
- time 00:00:00
- mode NORMAL
- prescaler and scan counter 0
- debouncer outputs 1 (released)
- press pulses 0
- digit_sel = 111110
- seg_out = 1000000
REQ-027 Reset SHALL override any in-progress key press or adjustment. A key held through reset release SHALL NOT generate a press pulse.

Structure
REQ-028 A shared package SHALL hold the mode state type (NORMAL/ADJ_HOUR/ADJ_MIN), the BCD-to-segment constant table, and the digit-index constants.
REQ-029 A single sub-module key_debounce (synchronizer, debouncer, falling-edge pulse; parameter DEBOUNCE_CYC) SHALL be instantiated once per key.

Verification
REQ-030 Reset, then 2*CLK_PER_SEC+2 cycles with keys released -> displayed time 00:00:02; the scan visits all six digit_sel codes.
REQ-031 From NORMAL, the following stimulus SHALL leave the display at 02:03:00; after 3*CLK_PER_SEC more cycles it SHALL show 02:03:03.
- mode press, then 2 inc presses
- mode press, then 3 inc presses
- mode press
REQ-032 Preload via 23 hour incs and 59 minute incs, return to NORMAL, run 60 s -> 00:00:00 (rollover). In ADJ_HOUR at 23, one inc -> 00.
REQ-033 Glitch test: key_inc low for DEBOUNCE_CYC-1 cycles in ADJ_MIN -> minutes unchanged; low for 5 cycles -> exactly +1.
REQ-034 Mode and inc pressed on the same cycle in ADJ_HOUR -> mode becomes ADJ_MIN and hours are unchanged. Inc in NORMAL -> no change.
REQ-035 rst asserted mid-adjust at 05:07 -> next cycle digit_sel = 111110, seg_out = 1000000, mode NORMAL, time 00:00:00.
